// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the matrix-multiply result collector.
//   - Default width constants (operand width, engine result width, output width).
//   - Collector state encoding.
//   - FIFO entry layout for the default configuration. The top level builds the
//     same layout locally from its own parameters.
package mm_pkg;

  localparam int N_DEF     = 20;
  localparam int RES_W_DEF = 2 * N_DEF;
  localparam int OUT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } mm_state_e;

  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    logic [N_DEF-1:0]     row;
    logic [N_DEF-1:0]     col;
    logic                 last;
  } mm_entry_t;

endpackage

// File: rtl/mm_res_fifo.sv
// mm_res_fifo: synchronous show-ahead FIFO.
// The head entry is visible on rdata_o whenever empty_o is low. The pointers
// carry one extra wrap bit so that full and empty can be told apart.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   srst_i         synchronous flush (both pointers back to zero)
//   push_i         write wdata_i (taken when not full, or when full with a pop)
//   pop_i          drop the head entry (ignored when empty)
//   rdata_o        head entry
//   full_o, empty_o occupancy flags
module mm_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         srst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push_s;
  logic         do_pop_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o;
  // With full and pop together the new word lands in the slot being vacated.
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointers: flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (srst_i) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; cleared on reset so the head never carries unknown data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (do_push_s && !srst_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mm_result_collector.sv
// mm_result_collector: captures matrix-multiply results (row-major, one per
// write pulse), tags them with (row, col) and streams them out on valid/ready.
// A FIFO absorbs sink backpressure because the engine cannot be stalled.
// Build option: define MM_RES_SAT_EN to saturate results to the signed OUT_W
// range (adds the sticky err_sat output); otherwise results are truncated.
// Ports:
//   clk, reset (async, active low)
//   start, cfg_rows, cfg_cols        job start and C dimensions
//   write, write_data, finish        engine result strobe/data, finish flag
//   out_valid/out_ready/out_data/out_row/out_col/out_last   result stream
//   busy, done                       COLLECT/DRAIN, DONE status
//   err_ovf, err_unexp, err_short    sticky protocol errors (err_sat optional)
module mm_result_collector
  import mm_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     cfg_rows,
  input  logic [N-1:0]     cfg_cols,
  input  logic             write,
  input  logic [2*N-1:0]   write_data,
  input  logic             finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [N-1:0]     out_row,
  output logic [N-1:0]     out_col,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err_ovf,
  output logic             err_unexp,
  output logic             err_short
`ifdef MM_RES_SAT_EN
  ,
  output logic             err_sat
`endif
);

  localparam int RES_W = 2 * N;
  localparam logic [N-1:0]     ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [RES_W-1:0] ONE_W = {{(RES_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [N-1:0]     row;
    logic [N-1:0]     col;
    logic             last;
  } entry_t;

  mm_state_e        state_q, state_d;
  logic [N-1:0]     rows_q, rows_d, cols_q, cols_d;
  logic [N-1:0]     wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [RES_W-1:0] total_q, total_d, cnt_q, cnt_d;
  logic             err_ovf_q, err_ovf_d, err_unexp_q, err_unexp_d;
  logic             err_short_q, err_short_d;
  logic [OUT_W-1:0] data_s;
  logic             last_s, push_req_s, push_s, pop_s, flush_s;
  logic             valid_s, full_s, empty_s;
  entry_t           wentry_s, head_s;

`ifdef MM_RES_SAT_EN
  logic clip_s, err_sat_q, err_sat_d;

  // Clamp v to the signed OUT_W range; the MSB of the result flags clipping.
  function automatic logic [OUT_W:0] sat_fn(input logic [RES_W-1:0] v);
    logic [RES_W-OUT_W:0] hi;
    hi = v[RES_W-1:OUT_W-1];
    if ((hi == {(RES_W-OUT_W+1){1'b0}}) || (hi == {(RES_W-OUT_W+1){1'b1}})) begin
      sat_fn = {1'b0, v[OUT_W-1:0]};
    end else if (v[RES_W-1]) begin
      sat_fn = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_fn = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  assign {clip_s, data_s} = sat_fn(write_data);
  assign err_sat = err_sat_q;
`else
  assign data_s = write_data[OUT_W-1:0];
  if (OUT_W < RES_W) begin : g_trunc
    logic unused_hi_s;
    assign unused_hi_s = ^write_data[RES_W-1:OUT_W];
  end
`endif

  assign last_s     = (wr_row_q == rows_q - ONE_N) && (wr_col_q == cols_q - ONE_N);
  assign wentry_s   = {data_s, wr_row_q, wr_col_q, last_s};
  assign valid_s    = !empty_s && ((state_q == ST_COLLECT) || (state_q == ST_DRAIN));
  assign pop_s      = valid_s && out_ready;
  assign push_req_s = write && (state_q == ST_COLLECT);
  assign push_s     = push_req_s && (!full_s || pop_s);

  mm_res_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .srst_i  (flush_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wentry_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Collector FSM, coordinate/count tracking and sticky error flags.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    total_d     = total_q;
    cnt_d       = cnt_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    err_ovf_d   = err_ovf_q;
    err_unexp_d = err_unexp_q;
    err_short_d = err_short_q;
    flush_s     = 1'b0;
`ifdef MM_RES_SAT_EN
    err_sat_d   = err_sat_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rows_d      = cfg_rows;
          cols_d      = cfg_cols;
          total_d     = {{N{1'b0}}, cfg_rows} * {{N{1'b0}}, cfg_cols};
          cnt_d       = {RES_W{1'b0}};
          wr_row_d    = {N{1'b0}};
          wr_col_d    = {N{1'b0}};
          err_ovf_d   = 1'b0;
          err_unexp_d = 1'b0;
          err_short_d = 1'b0;
`ifdef MM_RES_SAT_EN
          err_sat_d   = 1'b0;
`endif
          flush_s     = 1'b1;
          if ((cfg_rows == {N{1'b0}}) || (cfg_cols == {N{1'b0}})) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (write) begin
          err_unexp_d = 1'b1;
        end else begin
          err_unexp_d = err_unexp_q;
        end
      end
      ST_COLLECT: begin
        if (push_s) begin
          cnt_d = cnt_q + ONE_W;
          if (wr_col_q == cols_q - ONE_N) begin
            wr_col_d = {N{1'b0}};
            wr_row_d = wr_row_q + ONE_N;
          end else begin
            wr_col_d = wr_col_q + ONE_N;
            wr_row_d = wr_row_q;
          end
          if (cnt_q + ONE_W == total_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_COLLECT;
          end
`ifdef MM_RES_SAT_EN
          if (clip_s) begin
            err_sat_d = 1'b1;
          end else begin
            err_sat_d = err_sat_q;
          end
`endif
        end else begin
          cnt_d = cnt_q;
        end
        if (push_req_s && !push_s) begin
          err_ovf_d = 1'b1;
        end else begin
          err_ovf_d = err_ovf_q;
        end
        // A finish that coincides with the final push is not short.
        if (finish && (cnt_d != total_q)) begin
          err_short_d = 1'b1;
        end else begin
          err_short_d = err_short_q;
        end
      end
      ST_DRAIN: begin
        if (write) begin
          err_unexp_d = 1'b1;
        end else begin
          err_unexp_d = err_unexp_q;
        end
        if (pop_s && head_s.last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration, counters and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rows_q      <= {N{1'b0}};
      cols_q      <= {N{1'b0}};
      total_q     <= {RES_W{1'b0}};
      cnt_q       <= {RES_W{1'b0}};
      wr_row_q    <= {N{1'b0}};
      wr_col_q    <= {N{1'b0}};
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
      err_short_q <= 1'b0;
`ifdef MM_RES_SAT_EN
      err_sat_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      total_q     <= total_d;
      cnt_q       <= cnt_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
      err_short_q <= err_short_d;
`ifdef MM_RES_SAT_EN
      err_sat_q   <= err_sat_d;
`endif
    end
  end

  // Stream fields read as zero whenever no word is offered.
  assign out_valid = valid_s;
  assign out_data  = valid_s ? head_s.data : {OUT_W{1'b0}};
  assign out_row   = valid_s ? head_s.row  : {N{1'b0}};
  assign out_col   = valid_s ? head_s.col  : {N{1'b0}};
  assign out_last  = valid_s && head_s.last;
  assign busy      = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err_ovf   = err_ovf_q;
  assign err_unexp = err_unexp_q;
  assign err_short = err_short_q;

endmodule
